key_event_midi_tx: RTL
======================

# key_event_midi_tx

Downstream consumer of the keyboard scanner's 32-bit key-event words. Accepts one event per valid/ready handshake, maps key index to a MIDI note, and serialises a 3-byte Note-On/Note-Off message on a 31.25 kbaud UART line (8N1, LSB first). It sits between the event-FIFO drain path and the `midi_tx` pad, so scanned keys reach an external synth without CPU involvement.

## Interface
- `CLKS_PER_BIT`: default 800. Clock cycles per UART bit; must be ≥2. 800 at 25 MHz gives 31.25 kbaud.
- `BASE_NOTE`: default 36. MIDI note number assigned to key index 0.
- `clk`: in, 1. Single clock for the whole block.
- `rst`: in, 1. **Reset is synchronous and active-high.**
- `enable`: in, 1. Allows new events to be accepted.
- `midi_channel`: in, 4. MIDI channel. Sampled at event acceptance.
- `evt_valid`: in, 1. An event word is presented.
- `evt_data`: in, 32. Event word, with fields [31:24] timestamp (ignored), [16] pressed, [15:8] velocity, [7:0] key index. Bits [23:17] are ignored.
- `evt_ready`: out, 1. The block can accept an event.
- `midi_tx`: out, 1. UART serial output; idle level is 1.
- `busy`: out, 1. A message is being transmitted.
- `evt_dropped`: out, 1. One-cycle pulse when an accepted event is discarded.

## Operation
- States are IDLE and SEND.
- `evt_ready = (state==IDLE) && enable`. An event is accepted on the edge where `evt_valid && evt_ready` holds.
- Note computation: `note = BASE_NOTE + key`, computed 9 bits wide.
  - If `note > 127`, the event is dropped.
  - On a drop: `evt_dropped` = 1 for the following cycle, state stays IDLE, nothing is transmitted.
- Status byte:
  - pressed=1 gives `0x90 | midi_channel`.
  - pressed=0 gives `0x80 | midi_channel`.
- Data bytes: `note[6:0]`, then the velocity byte.
  - Note-On velocity is `velocity & 0x7F`, forced to 0x01 if the result is 0.
  - Note-Off velocity is fixed at 0x40.
- Each byte is sent as: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Bytes are sent back-to-back with no idle gap between one byte's stop bit and the next start bit.
- After the last stop bit, state returns to IDLE.
- If `enable` falls during SEND, the current message completes in full; messages are never truncated. No new event is accepted while `enable`=0.
- `evt_valid` is not required to stay stable once the event is accepted, because fields are latched at acceptance.
- Reset values:
  - `midi_tx`=1, `busy`=0, `evt_ready`=0 during reset, `evt_dropped`=0.
  - All counters are 0, state is IDLE.
- Reset asserted mid-message aborts the message. `midi_tx` is 1 from the first edge with `rst`=1.

## Timing
- Acceptance edge is T. `midi_tx` drives the start bit from T+1 (registered output).
- `busy` is 1 from T+1 until the end of the final stop bit.
- A full 3-byte message occupies `30*CLKS_PER_BIT` cycles starting at T+1.
- `evt_ready` reasserts on the edge the last stop bit ends, at T + 30*CLKS_PER_BIT. A waiting event is accepted on that edge, so there is zero gap between messages.
- Bit counter runs 0..9 per byte, byte counter 0..2. The cycle divider wraps at `CLKS_PER_BIT-1`.
- A drop costs one cycle. `evt_ready` stays high, so back-to-back dropped events can be accepted every cycle.

## Configuration
- Macro: `KEY_MIDI_RUNNING_STATUS_EN`.
- **Defined:**
  - The last transmitted status byte is remembered.
  - If the new status byte equals the remembered one, the status byte is omitted. The message is then 2 bytes and takes `20*CLKS_PER_BIT` cycles.
  - The remembered status is invalidated by: reset, `enable`=0 in IDLE, or a change of `midi_channel`.
  - A dropped event does not change the remembered status.
- **Undefined:** every message carries its status byte, and the block contains no status-memory logic.

## Structure
- Package `keyboard_midi_pkg` holds:
  - Event field bit positions (EVT_KEY_LSB=0, EVT_VEL_LSB=8, EVT_PRESSED_BIT=16).
  - MIDI_NOTE_ON=8'h90, MIDI_NOTE_OFF=8'h80, NOTE_OFF_VEL=8'h40.
  - The state enum.
- Sub-module `midi_uart_tx` is a byte serialiser with a `byte_valid`/`byte_ready` handshake and `CLKS_PER_BIT` parameter. It provides the back-to-back guarantee: `byte_ready` is high during the final stop-bit cycle.
- The top level sequences the bytes and performs note mapping and drop handling.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Reset with `evt_valid`=0 -> `midi_tx`=1, `busy`=0; after `rst` falls with `enable`=1, `evt_ready`=1.
- Event key=5, pressed=1, vel=0x64, channel=2 -> line carries bytes 0x92, 0x29, 0x64 with 8N1 framing; `busy` high for 120 cycles; `evt_ready` returns at T+120.
- Event key=3, pressed=0 -> bytes 0x80|ch, 0x27, 0x40. Event with pressed=1, vel=0x80 -> velocity byte 0x01.
- `BASE_NOTE`=100, key=30 -> `evt_dropped` pulses once; `midi_tx` stays 1; `evt_ready` stays high.
- Two queued presses on the same channel with `KEY_MIDI_RUNNING_STATUS_EN` defined -> 3 bytes then 2 bytes, total 200 cycles, no idle gap. Without the macro -> 240 cycles.
- `rst` asserted during the second byte -> `midi_tx`=1 from the next edge; a fresh event afterwards produces a complete message.

Source files
------------

// File: rtl/keyboard_midi_pkg.sv
// Shared event-field positions, MIDI constants and the sequencer state type.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package keyboard_midi_pkg;

   localparam int EVT_KEY_LSB     = 0;
   localparam int EVT_VEL_LSB     = 8;
   localparam int EVT_PRESSED_BIT = 16;

   localparam logic [7:0] MIDI_NOTE_ON  = 8'h90;
   localparam logic [7:0] MIDI_NOTE_OFF = 8'h80;
   localparam logic [7:0] NOTE_OFF_VEL  = 8'h40;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } tx_state_t;

   // A Note-On with velocity 0 would read as Note-Off, so the floor is 1.
   function automatic logic [7:0] on_velocity(input logic [7:0] vel);
      logic [7:0] v7;
      v7 = vel & 8'h7F;
      return (v7 == 8'h00) ? 8'h01 : v7;
   endfunction

endpackage

// File: rtl/midi_uart_tx.sv
// 8N1 byte serialiser, LSB first, CLKS_PER_BIT cycles per bit.
// Latency: start bit on the line the cycle after the accepting edge.
// Backpressure: byte_ready is high when idle and in the final stop-bit cycle, so bytes chain with no gap.
module midi_uart_tx #(
   parameter int CLKS_PER_BIT = 800
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic       stop_near,
   output logic       tx,
   output logic       active
);

   localparam int DIV_W = $clog2(CLKS_PER_BIT);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [DIV_W-1:0] DIV_NEAR = DIV_W'(CLKS_PER_BIT - 2);

   logic [DIV_W-1:0] div;
   logic [3:0]       bit_cnt;
   logic [7:0]       shreg;
   logic             last_div;

   assign last_div   = (div == DIV_LAST);
   assign byte_ready = !active || ((bit_cnt == 4'd9) && last_div);
   // One cycle ahead of the final stop-bit cycle; lets the sequencer reopen early.
   assign stop_near  = active && (bit_cnt == 4'd9) && (div == DIV_NEAR);

   // Bit timing and shifting; a new byte may be loaded on the last stop-bit cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         div     <= '0;
         bit_cnt <= 4'd0;
         shreg   <= 8'h00;
         tx      <= 1'b1;
         active  <= 1'b0;
      end else if (byte_valid && byte_ready) begin
         div     <= '0;
         bit_cnt <= 4'd0;
         shreg   <= byte_data;
         tx      <= 1'b0;
         active  <= 1'b1;
      end else if (active) begin
         if (last_div) begin
            div <= '0;
            if (bit_cnt == 4'd9) begin
               bit_cnt <= 4'd0;
               active  <= 1'b0;
               tx      <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
               if (bit_cnt == 4'd8) begin
                  tx <= 1'b1;
               end else begin
                  tx    <= shreg[0];
                  shreg <= {1'b0, shreg[7:1]};
               end
            end
         end else begin
            div <= div + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/key_event_midi_tx.sv
// Key-event word to MIDI Note-On/Off message on a UART pin; optional running status via KEY_MIDI_RUNNING_STATUS_EN.
// Latency: start bit drives midi_tx the cycle after acceptance; 3-byte message lasts 30*CLKS_PER_BIT cycles.
// Backpressure: evt_ready only in IDLE with enable; IDLE reopens for the last stop-bit cycle so queued events chain gap-free.
module key_event_midi_tx
   import keyboard_midi_pkg::*;
#(
   parameter int CLKS_PER_BIT = 800,
   parameter int BASE_NOTE    = 36
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [3:0]  midi_channel,
   input  logic        evt_valid,
   input  logic [31:0] evt_data,
   output logic        evt_ready,
   output logic        midi_tx,
   output logic        busy,
   output logic        evt_dropped
);

   tx_state_t   state, state_nxt;
   logic [1:0]  byte_cnt;
   logic [7:0]  note_q, vel_q;
   logic [7:0]  key, vel_raw, status_in, vel_in, byte_data;
   logic [8:0]  note9;
   logic        pressed, drop, accept, send_ok, skip_status;
   logic        byte_valid, byte_ready, stop_near;
   logic        unused_evt_bits;

   assign key       = evt_data[EVT_KEY_LSB +: 8];
   assign vel_raw   = evt_data[EVT_VEL_LSB +: 8];
   assign pressed   = evt_data[EVT_PRESSED_BIT];
   assign unused_evt_bits = ^evt_data[31:17];

   assign note9     = 9'(BASE_NOTE) + {1'b0, key};
   assign drop      = (note9 > 9'd127);
   assign status_in = (pressed ? MIDI_NOTE_ON : MIDI_NOTE_OFF) | {4'h0, midi_channel};
   assign vel_in    = pressed ? on_velocity(vel_raw) : NOTE_OFF_VEL;

   // Acceptance uses the state directly so the handshake has no loop through the output block.
   assign accept  = evt_valid && (state == IDLE) && enable && !rst;
   assign send_ok = accept && !drop;

`ifdef KEY_MIDI_RUNNING_STATUS_EN
   logic       rs_valid;
   logic [7:0] rs_status;
   logic [3:0] chan_q;

   assign skip_status = rs_valid && (rs_status == status_in);

   // Remember the last status sent; forget it on disable-while-idle or a channel change.
   always_ff @(posedge clk) begin
      if (rst) begin
         rs_valid  <= 1'b0;
         rs_status <= 8'h00;
         chan_q    <= 4'd0;
      end else begin
         chan_q <= midi_channel;
         if (send_ok) begin
            rs_valid  <= 1'b1;
            rs_status <= status_in;
         end else if ((!enable && (state == IDLE)) || (midi_channel != chan_q)) begin
            rs_valid <= 1'b0;
         end
      end
   end
`else
   assign skip_status = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: leave SEND one cycle before the final stop bit ends.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (send_ok) state_nxt = SEND;
         SEND:    if (stop_near && (byte_cnt == 2'd2)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: handshake and the byte offered to the serialiser.
   always_comb begin
      evt_ready  = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      case (state)
         IDLE: begin
            evt_ready  = enable && !rst;
            byte_valid = send_ok;
            byte_data  = skip_status ? {1'b0, note9[6:0]} : status_in;
         end
         SEND: begin
            byte_valid = byte_ready && (byte_cnt != 2'd2);
            byte_data  = (byte_cnt == 2'd0) ? note_q : vel_q;
         end
         default: ;
      endcase
   end

   // Latch message fields at acceptance and count bytes handed to the serialiser.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt    <= 2'd0;
         note_q      <= 8'h00;
         vel_q       <= 8'h00;
         evt_dropped <= 1'b0;
      end else begin
         evt_dropped <= accept && drop;
         if (send_ok) begin
            note_q   <= {1'b0, note9[6:0]};
            vel_q    <= vel_in;
            byte_cnt <= skip_status ? 2'd1 : 2'd0;
         end else if ((state == SEND) && byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
         end
      end
   end

   midi_uart_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .clk       (clk),
      .rst       (rst),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .byte_ready(byte_ready),
      .stop_near (stop_near),
      .tx        (midi_tx),
      .active    (busy)
   );

endmodule
